trace_capture_unit: RTL and testbench
=====================================

# trace_capture_unit

Synthesizable per-instruction trace buffer for the single-cycle MIPS datapath. It replaces simulation-only `$monitor` dumps with an on-chip capture memory. It samples the committed-instruction state (PC, instruction, write-back destination and data, write enables) once per clock into a parametrised buffer, and supports three capture modes: continuous, PC-triggered ring with post-trigger count, and write-filtered. Captured entries drain oldest-first through a valid/ready read port. The block sits beside `single_cycle_mips` and taps its internal nets.

## Interface

Parameters:

- `DATA_WIDTH`, default 16: width of `write_back`.
- `PC_WIDTH`, default 10: width of `pc` and `trig_pc`.
- `REG_ADDR_WIDTH`, default 4: width of `write_reg`.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `ENTRY_W`, derived: PC_WIDTH+32+REG_ADDR_WIDTH+2+DATA_WIDTH (64 at defaults).

Ports:

- `clock`  in  1: rising-edge clock, same as the processor.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse; clears the buffer, latches configuration, arms capture.
- `mode`  in  2: 00 continuous, 01 triggered ring, 10 write-filtered, 11 treated as 00. Latched on `start`.
- `trig_pc`  in  PC_WIDTH: trigger PC for mode 01. Latched on `start`.
- `post_count`  in  $clog2(DEPTH)+1: entries captured after the trigger entry. Latched on `start`.
- `pc`  in  PC_WIDTH: processor PC.
- `instruction`  in  32: processor instruction.
- `write_reg`  in  REG_ADDR_WIDTH: register-file write address.
- `write_back`  in  DATA_WIDTH: register-file write data.
- `reg_write`  in  1: register write enable.
- `mem_write`  in  1: memory write enable.
- `rd_valid`  out  1: head entry available.
- `rd_data`  out  ENTRY_W: head entry, packed MSB→LSB as {pc, instruction, write_reg, reg_write, mem_write, write_back}.
- `rd_ready`  in  1: consumer accepts the head entry.
- `state`  out  2: 00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- `count`  out  $clog2(DEPTH)+1: entries held, 0..DEPTH.
- `overflow`  out  1: sticky; a qualifying cycle was dropped because the buffer was full.

## Operation

- **Reset:** `state`=IDLE, `count`=0, write/read pointers 0, `overflow`=0, `rd_valid`=0, `rd_data`=0. Memory contents are not reset.
- **`start`** in any state clears `count`, pointers and `overflow`, latches `mode`/`trig_pc`/`post_count`, and sets `state` to ARMED. A `start` during ARMED or POST restarts capture.
- **ARMED, mode 00:** write one entry every cycle.
  - Transition to DONE on the edge where `count` reaches DEPTH.
- **ARMED, mode 10:** write only on cycles where `reg_write|mem_write`=1.
  - Transition to DONE when `count` reaches DEPTH.
- **`overflow`** is set in modes 00/10 only if a qualifying cycle occurs while the buffer is full. It is reachable only on the DONE-transition edge boundary, i.e. it stays 0 unless `start` collides; DONE itself never captures.
- **ARMED, mode 01:** write every cycle as a ring.
  - When full, the new entry overwrites the oldest, the read pointer advances, and `count` stays at DEPTH.
  - When `pc`==latched `trig_pc`, that cycle's entry is written. If `post_count`=0 the next state is DONE; otherwise it is POST with the down-counter loaded from `post_count`.
- **POST:** write every cycle (ring semantics) and decrement the counter. The edge that writes with counter=1 moves to DONE.
- **DONE:** no capture.
  - `rd_valid` = (`count`≠0).
  - `rd_data` = mem[rd_ptr]. It is combinational and forced to 0 when `rd_valid`=0.
  - `rd_valid`&&`rd_ready` pops the entry: rd_ptr+1 mod DEPTH, `count`−1.
- **Reads in other states:** `rd_valid`=0 in IDLE/ARMED/POST; `rd_ready` is ignored.
- **Pointers:** $clog2(DEPTH) bits, wrapping naturally.
- **Stale pops:** DONE with `count`=0 stays DONE until `start`.

## Timing

- Inputs are sampled at the rising edge; one entry per edge maximum.
- `start` sampled at edge N gives ARMED after N. The first capture is at edge N+1.
- A trigger seen at edge T with `post_count`=P: the last entry is written at edge T+P, and `state`=DONE after it.
- Read is zero-latency: `rd_data` is valid in the same cycle as `rd_valid`. It holds stable while `rd_valid`&&!`rd_ready`. With `rd_ready` held high, one entry pops per cycle.
- `reset_n` low forces reset values immediately, independent of `clock`, including mid-POST or mid-readout.

## Test plan

- Mode 00, DEPTH=16, `pc` counting 0..19 → DONE after pc 15 captured, `count`=16, `overflow`=0. With `rd_ready`=1, 16 consecutive beats return pc 0..15, then `rd_valid`=0.
- Mode 01, `trig_pc`=20, `post_count`=3, `pc` counting from 0 → DONE after pc 23 captured. Readout returns pc 8..23 in order.
- Mode 01, `trig_pc`=5, `post_count`=0 → DONE at pc 5, `count`=6, readout pc 0..5.
- Mode 10, `reg_write` high on even pc only, pc 0..40 → entries are pc 0,2,…,30 with `reg_write`=1.
- Readout with `rd_ready` toggled 1,0,0,1… → `rd_data` unchanged across stalled cycles, no entry skipped or duplicated.
- `reset_n` pulsed low mid-POST → `state`=IDLE, `count`=0, `rd_valid`=0 asynchronously. A subsequent `start` in mode 00 behaves as in the first scenario. `start` during ARMED clears `count` to 0 on the next edge.

Source files
------------

// File: rtl/trace_capture_unit.sv
// Per-instruction trace buffer for the single-cycle MIPS datapath.
// Captures commit state into a ring memory and drains it oldest-first.
module trace_capture_unit #(
   parameter int DATA_WIDTH     = 16,
   parameter int PC_WIDTH       = 10,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int DEPTH          = 16,
   parameter int ENTRY_W        =
      PC_WIDTH + 32 + REG_ADDR_WIDTH + 2 + DATA_WIDTH
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [1:0]                  mode,
   input  logic [PC_WIDTH-1:0]         trig_pc,
   input  logic [$clog2(DEPTH):0]      post_count,
   input  logic [PC_WIDTH-1:0]         pc,
   input  logic [31:0]                 instruction,
   input  logic [REG_ADDR_WIDTH-1:0]   write_reg,
   input  logic [DATA_WIDTH-1:0]       write_back,
   input  logic                        reg_write,
   input  logic                        mem_write,
   output logic                        rd_valid,
   output logic [ENTRY_W-1:0]          rd_data,
   input  logic                        rd_ready,
   output logic [1:0]                  state,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [AW-1:0] INC_P  = AW'(1);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_ARMED = 2'b01;
   localparam logic [1:0] S_POST  = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   logic [1:0]          state_q, state_d;
   logic [1:0]          mode_q;
   logic [PC_WIDTH-1:0] trig_q;
   logic [CW-1:0]       post_q, post_cnt;
   logic [CW-1:0]       count_q;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic                ovf_q;

   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic [ENTRY_W-1:0]  entry;

   logic ring, qual, full, hit;
   logic wr_en, ring_adv, drop, pop;

   assign entry = {pc, instruction, write_reg,
                   reg_write, mem_write, write_back};

   assign ring = (mode_q == 2'b01);
   assign qual = (mode_q != 2'b10) | reg_write | mem_write;
   assign full = (count_q == FULL_C);
   assign hit  = (pc == trig_q);

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = S_ARMED;
      end else begin
         unique case (state_q)
            S_ARMED: begin
               if (ring) begin
                  if (hit)
                     state_d = (post_q == '0) ? S_DONE : S_POST;
               end else if (full ||
                            (wr_en && count_q == LAST_C)) begin
                  state_d = S_DONE;
               end
            end
            S_POST:
               if (post_cnt == ONE_C) state_d = S_DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // per-cycle actions
   always_comb begin
      wr_en = 1'b0;
      drop  = 1'b0;
      pop   = 1'b0;
      if (!start) begin
         unique case (1'b1)
            (state_q == S_ARMED): begin
               if (ring)      wr_en = 1'b1;
               else if (qual) begin
                  drop  = full;
                  wr_en = !full;
               end
            end
            (state_q == S_POST): wr_en = 1'b1;
            (state_q == S_DONE):
               pop = rd_ready && (count_q != '0);
            default: ;
         endcase
      end
   end

   // only ring modes can write into a full buffer
   assign ring_adv = wr_en && full;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_q   <= 2'b00;
         trig_q   <= '0;
         post_q   <= '0;
         post_cnt <= '0;
         count_q  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf_q    <= 1'b0;
      end else if (start) begin
         mode_q   <= (mode == 2'b11) ? 2'b00 : mode;
         trig_q   <= trig_pc;
         post_q   <= post_count;
         count_q  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (drop) ovf_q <= 1'b1;
         if (wr_en) begin
            wr_ptr <= wr_ptr + INC_P;
            if (ring_adv) rd_ptr  <= rd_ptr + INC_P;
            else          count_q <= count_q + ONE_C;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + INC_P;
            count_q <= count_q - ONE_C;
         end
         if (state_q == S_ARMED && ring && hit)
            post_cnt <= post_q;
         else if (state_q == S_POST)
            post_cnt <= post_cnt - ONE_C;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   assign rd_valid = (state_q == S_DONE) && (count_q != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign state    = state_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Directed bench for trace_capture_unit with a queue-based
// reference model compared against the DUT every cycle.
module tb_trace_capture_unit;

   localparam int DW = 16;
   localparam int PW = 10;
   localparam int RW = 4;
   localparam int D  = 16;
   localparam int EW = PW + 32 + RW + 2 + DW;
   localparam int CW = $clog2(D) + 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [PW-1:0] trig_pc = '0;
   logic [CW-1:0] post_count = '0;
   logic [PW-1:0] pc = '0;
   logic [31:0]   instruction = '0;
   logic [RW-1:0] write_reg = '0;
   logic [DW-1:0] write_back = '0;
   logic          reg_write = 1'b0;
   logic          mem_write = 1'b0;
   logic          rd_ready = 1'b0;
   logic          rd_valid;
   logic [EW-1:0] rd_data;
   logic [1:0]    state;
   logic [CW-1:0] count;
   logic          overflow;

   int total = 0;
   int bad = 0;

   trace_capture_unit dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .mode(mode), .trig_pc(trig_pc),
      .post_count(post_count), .pc(pc),
      .instruction(instruction), .write_reg(write_reg),
      .write_back(write_back), .reg_write(reg_write),
      .mem_write(mem_write), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_ready(rd_ready),
      .state(state), .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm,
                      input logic [EW-1:0] act,
                      input logic [EW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // reference model: a queue of entries, oldest at the front
   logic [EW-1:0] mq[$];
   int  mst = 0;
   int  mmode = 0;
   int  mtrig = 0;
   int  mpost = 0;
   int  mcnt = 0;
   bit  movf = 0;

   function automatic void push_ring(input logic [EW-1:0] e);
      if (mq.size() == D) void'(mq.pop_front());
      mq.push_back(e);
   endfunction

   always @(posedge clock or negedge reset_n) begin
      logic [EW-1:0] e;
      e = {pc, instruction, write_reg,
           reg_write, mem_write, write_back};
      if (!reset_n) begin
         mq.delete();
         mst  = 0;
         movf = 0;
      end else if (start) begin
         mq.delete();
         movf  = 0;
         mst   = 1;
         mmode = (mode == 2'b11) ? 0 : int'(mode);
         mtrig = int'(trig_pc);
         mpost = int'(post_count);
      end else begin
         case (mst)
            1: begin
               if (mmode == 1) begin
                  push_ring(e);
                  if (int'(pc) == mtrig) begin
                     if (mpost == 0) mst = 3;
                     else begin
                        mcnt = mpost;
                        mst  = 2;
                     end
                  end
               end else if (mmode == 0 || reg_write ||
                            mem_write) begin
                  if (mq.size() == D) movf = 1;
                  else begin
                     mq.push_back(e);
                     if (mq.size() == D) mst = 3;
                  end
               end
            end
            2: begin
               push_ring(e);
               mcnt--;
               if (mcnt == 0) mst = 3;
            end
            3: if (mq.size() > 0 && rd_ready)
                  void'(mq.pop_front());
            default: ;
         endcase
      end
   end

   always @(negedge clock) begin
      logic ev;
      logic [EW-1:0] ed;
      ev = (mst == 3) && (mq.size() > 0);
      ed = '0;
      if (ev) ed = mq[0];
      chk("state", EW'(state), EW'(mst));
      chk("count", EW'(count), EW'(mq.size()));
      chk("rd_valid", EW'(rd_valid), EW'(ev));
      chk("rd_data", rd_data, ed);
      chk("overflow", EW'(overflow), EW'(movf));
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic set_cpu(input int p);
      pc          = PW'(p);
      instruction = 32'h2400_0000 | 32'(p * 37);
      write_reg   = RW'(p);
      write_back  = DW'(p * 613 + 11);
      reg_write   = (p % 2 == 0);
      mem_write   = 1'b0;
   endtask

   task automatic run(input int from, input int to);
      for (int p = from; p <= to; p++) begin
         set_cpu(p);
         tick();
      end
   endtask

   task automatic do_start(input logic [1:0] m,
                           input int t, input int pst);
      start      = 1'b1;
      mode       = m;
      trig_pc    = PW'(t);
      post_count = CW'(pst);
      tick();
      start = 1'b0;
   endtask

   task automatic drain(input int exp[$], input bit stall,
                        input bit want_rw);
      int got[$];
      for (int c = 0; c < 100 && got.size() < exp.size();
           c++) begin
         rd_ready = stall ? (c % 3 == 0) : 1'b1;
         if (rd_valid && rd_ready) begin
            got.push_back(int'(rd_data[EW-1 -: PW]));
            if (want_rw)
               chk("drain_rw", EW'(rd_data[DW+1]), EW'(1));
         end
         tick();
      end
      rd_ready = 1'b0;
      chk("drain_n", EW'(got.size()), EW'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         if (i < got.size())
            chk("drain_pc", EW'(got[i]), EW'(exp[i]));
      chk("drain_empty", EW'(rd_valid), EW'(0));
   endtask

   initial begin
      int e[$];
      #2;
      chk("rst_state", EW'(state), EW'(0));
      chk("rst_count", EW'(count), EW'(0));
      chk("rst_valid", EW'(rd_valid), EW'(0));
      chk("rst_data", rd_data, '0);
      chk("rst_ovf", EW'(overflow), EW'(0));
      tick();
      reset_n = 1'b1;
      tick();

      // continuous capture
      do_start(2'b00, 0, 0);
      run(0, 19);
      chk("s1_count", EW'(count), EW'(16));
      chk("s1_state", EW'(state), EW'(3));
      chk("s1_ovf", EW'(overflow), EW'(0));
      e.delete();
      for (int i = 0; i <= 15; i++) e.push_back(i);
      drain(e, 0, 0);

      // trigger with post count
      do_start(2'b01, 20, 3);
      run(0, 29);
      chk("s2_count", EW'(count), EW'(16));
      chk("s2_state", EW'(state), EW'(3));
      e.delete();
      for (int i = 8; i <= 23; i++) e.push_back(i);
      drain(e, 0, 0);

      // trigger with zero post count
      do_start(2'b01, 5, 0);
      run(0, 9);
      chk("s3_count", EW'(count), EW'(6));
      e.delete();
      for (int i = 0; i <= 5; i++) e.push_back(i);
      drain(e, 0, 0);

      // write-filtered, stalled readout
      do_start(2'b10, 0, 0);
      run(0, 40);
      chk("s4_count", EW'(count), EW'(16));
      e.delete();
      for (int i = 0; i <= 30; i += 2) e.push_back(i);
      drain(e, 1, 1);

      // asynchronous reset during POST
      do_start(2'b01, 20, 10);
      run(0, 24);
      chk("s5_post", EW'(state), EW'(2));
      #3 reset_n = 1'b0;
      #1;
      chk("s5_state", EW'(state), EW'(0));
      chk("s5_count", EW'(count), EW'(0));
      chk("s5_valid", EW'(rd_valid), EW'(0));
      #2 reset_n = 1'b1;
      tick();

      do_start(2'b00, 0, 0);
      run(0, 19);
      chk("s6_count", EW'(count), EW'(16));
      e.delete();
      for (int i = 0; i <= 15; i++) e.push_back(i);
      drain(e, 0, 0);

      // restart while armed, mode 11 acts as continuous
      do_start(2'b11, 0, 0);
      run(0, 4);
      chk("s7_pre", EW'(count), EW'(5));
      do_start(2'b00, 0, 0);
      chk("s7_count", EW'(count), EW'(0));
      chk("s7_state", EW'(state), EW'(1));
      run(100, 110);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
